// File: rtl/lsu.sv
// Load/store unit: drives 8-byte-aligned data-memory beats, splits accesses that
// straddle a doubleword boundary into two beats and returns extended load data.
module lsu #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic        rd_en,
    output logic [63:0] rd_addr,
    input  logic [63:0] rd_data,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [63:0] wr_data,
    output logic [7:0]  wr_len
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

    function automatic logic [15:0] lane_mask(input logic [2:0] f3, input logic [2:0] off);
        logic [15:0] m;
        m = (16'd1 << (4'd1 << f3[1:0])) - 16'd1;
        return m << off;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
        logic [2:0] nm1;
        case (f3[1:0])
            2'd0:    nm1 = 3'd0;
            2'd1:    nm1 = 3'd1;
            2'd2:    nm1 = 3'd3;
            default: nm1 = 3'd7;
        endcase
        return |(off & nm1);
    endfunction

    // hi is the second beat (zero when the access did not cross).
    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] hi, input logic [63:0] lo);
        logic [63:0] s;
        s = 64'({hi, lo} >> {off, 3'b000});
        case (f3[1:0])
            2'd0:    return f3[2] ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            2'd1:    return f3[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    return f3[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_lo;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [63:0] r_resp_rdata;
    logic        r_rd_en;
    logic [63:0] r_rd_addr;
    logic        r_wr_en;
    logic [63:0] r_wr_addr;
    logic [63:0] r_wr_data;
    logic [7:0]  r_wr_len;

    logic        w_req_err;
    logic [7:0]  w_req_mlo;
    logic [63:0] w_req_a0;
    logic [2:0]  w_off;
    logic [15:0] w_mask;
    logic        w_cross;
    logic [63:0] w_a1;

    assign w_req_mlo = 8'(lane_mask(req_funct3, req_addr[2:0]));
    assign w_req_a0  = {req_addr[63:3], 3'b000};
    assign w_req_err = (req_we ? req_funct3[2] : (req_funct3 == 3'b111)) ||
                       (!ALLOW_MISALIGN && misaligned(req_funct3, req_addr[2:0]));

    assign w_off   = r_addr[2:0];
    assign w_mask  = lane_mask(r_funct3, w_off);
    assign w_cross = |w_mask[15:8];
    assign w_a1    = {r_addr[63:3], 3'b000} + 64'd8;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_funct3     <= 3'd0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_lo         <= 64'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 64'd0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= 64'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 64'd0;
            r_wr_data    <= 64'd0;
            r_wr_len     <= 8'd0;
        end else begin
            // NOTE: these non-blocking defaults are overridden below by any later
            // assignment in the same edge, so strobes and response fields last
            // exactly one cycle without explicit clearing in every state.
            r_rd_en      <= 1'b0;
            r_rd_addr    <= 64'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 64'd0;
            r_wr_data    <= 64'd0;
            r_wr_len     <= 8'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 64'd0;

            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_funct3    <= req_funct3;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!req_we) begin
                            r_state   <= RD0;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_req_a0;
                        end else begin
                            r_state   <= WR0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_req_a0;
                            r_wr_data <= req_wdata << {req_addr[2:0], 3'b000};
                            r_wr_len  <= w_req_mlo;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                RD0: begin
                    r_lo <= rd_data;
                    if (w_cross) begin
                        r_state   <= RD1;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_a1;
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= extend(r_funct3, w_off, 64'd0, rd_data);
                    end
                end
                RD1: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= extend(r_funct3, w_off, rd_data, r_lo);
                end
                WR0: begin
                    if (w_cross) begin
                        r_state   <= WR1;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_a1;
                        // Crossing implies off >= 1, so the shift stays below 64.
                        r_wr_data <= r_wdata >> {(4'd8 - {1'b0, w_off}), 3'b000};
                        r_wr_len  <= w_mask[15:8];
                    end else begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end
                end
                WR1: begin
                    r_state      <= RESP;
                    r_resp_valid <= 1'b1;
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_len     = r_wr_len;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one instance with misaligned splitting, one without,
// sharing an 8-doubleword memory model indexed by address bits [5:3].
module tb_lsu;

    localparam logic [63:0] B = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid0, req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err, rd_en, wr_en;
    logic [63:0] resp_rdata, rd_addr, rd_data, wr_addr, wr_data;
    logic [7:0]  wr_len;
    logic        req_ready0, resp_valid0, resp_err0, rd_en0, wr_en0;
    logic [63:0] resp_rdata0, rd_addr0, rd_data0, wr_addr0, wr_data0;
    logic [7:0]  wr_len0;

    lsu #(.ALLOW_MISALIGN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len)
    );

    lsu #(.ALLOW_MISALIGN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_err(resp_err0), .resp_rdata(resp_rdata0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_len(wr_len0)
    );

    logic [63:0] mem [8];
    logic        poke_en;
    logic [2:0]  poke_idx;
    logic [63:0] poke_val;

    assign rd_data  = mem[rd_addr[5:3]];
    assign rd_data0 = mem[rd_addr0[5:3]];

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_idx] <= poke_val;
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++)
                if (wr_len[i]) mem[wr_addr[5:3]][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          lat, nrd, nwr, both;
    logic        got_err;
    logic [63:0] got_rdata;
    logic [63:0] cap_rd_addr [2];
    logic [63:0] cap_wr_addr [2];
    logic [63:0] cap_wr_data [2];
    logic [7:0]  cap_wr_len  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [2:0] idx, input logic [63:0] val);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge with the selected instance idle; returns at a negedge.
    task automatic issue(input logic sel, input logic we, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata, input string tag);
        logic s_rd, s_wr;
        check({tag, "/ready"}, 64'(sel ? req_ready0 : req_ready), 64'd1);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (sel) req_valid0 = 1'b1;
        else     req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        lat = 0; nrd = 0; nwr = 0; got_err = 1'b0; got_rdata = 64'd0;
        for (int k = 0; k < 2; k++) begin
            cap_rd_addr[k] = '0; cap_wr_addr[k] = '0; cap_wr_data[k] = '0; cap_wr_len[k] = '0;
        end
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            s_rd = sel ? rd_en0 : rd_en;
            s_wr = sel ? wr_en0 : wr_en;
            if (s_rd) begin
                if (nrd < 2) cap_rd_addr[nrd] = sel ? rd_addr0 : rd_addr;
                nrd++;
            end
            if (s_wr) begin
                if (nwr < 2) begin
                    cap_wr_addr[nwr] = sel ? wr_addr0 : wr_addr;
                    cap_wr_data[nwr] = sel ? wr_data0 : wr_data;
                    cap_wr_len[nwr]  = sel ? wr_len0  : wr_len;
                end
                nwr++;
            end
            if (s_rd && s_wr) both++;
            if (sel ? resp_valid0 : resp_valid) begin
                lat       = c;
                got_err   = sel ? resp_err0 : resp_err;
                got_rdata = sel ? resp_rdata0 : resp_rdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic expect_resp(input string tag, input int e_lat, input logic e_err,
                               input logic [63:0] e_rdata, input int e_nrd, input int e_nwr);
        check({tag, "/latency"}, 64'(lat), 64'(e_lat));
        check({tag, "/err"},     64'(got_err), 64'(e_err));
        check({tag, "/rdata"},   got_rdata, e_rdata);
        check({tag, "/rd_beats"}, 64'(nrd), 64'(e_nrd));
        check({tag, "/wr_beats"}, 64'(nwr), 64'(e_nwr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
        poke_en = 1'b0; poke_idx = 3'd0; poke_val = 64'd0;
        both = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst/req_ready",  64'(req_ready), 64'd0);
        check("rst/resp_valid", 64'(resp_valid), 64'd0);
        check("rst/rd_en",      64'(rd_en), 64'd0);
        check("rst/wr_en",      64'(wr_en), 64'd0);
        check("rst/rd_addr",    rd_addr, 64'd0);
        check("rst/wr_len",     64'(wr_len), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: aligned LD
        poke(3'd0, 64'h1122_3344_5566_7788);
        issue(1'b0, 1'b0, 3'b011, B, 64'd0, "LD");
        expect_resp("LD", 2, 1'b0, 64'h1122_3344_5566_7788, 1, 0);
        check("LD/rd_addr", cap_rd_addr[0], B);

        // 2: sign/zero extension
        poke(3'd0, 64'h0000_0000_0000_80F0);
        poke(3'd1, 64'd0);
        issue(1'b0, 1'b0, 3'b000, B, 64'd0, "LB");
        expect_resp("LB", 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0);
        issue(1'b0, 1'b0, 3'b100, B, 64'd0, "LBU");
        expect_resp("LBU", 2, 1'b0, 64'h0000_0000_0000_00F0, 1, 0);
        issue(1'b0, 1'b0, 3'b001, B, 64'd0, "LH");
        expect_resp("LH", 2, 1'b0, 64'hFFFF_FFFF_FFFF_80F0, 1, 0);
        issue(1'b0, 1'b0, 3'b101, B, 64'd0, "LHU");
        expect_resp("LHU", 2, 1'b0, 64'h0000_0000_0000_80F0, 1, 0);

        // 3: crossing SW
        issue(1'b0, 1'b1, 3'b010, B + 64'd6, 64'h0000_0000_AABB_CCDD, "SW");
        expect_resp("SW", 3, 1'b0, 64'd0, 0, 2);
        check("SW/wr0_addr", cap_wr_addr[0], B);
        check("SW/wr0_len",  64'(cap_wr_len[0]), 64'h00C0);
        check("SW/wr0_data", cap_wr_data[0], 64'hCCDD_0000_0000_0000);
        check("SW/wr1_addr", cap_wr_addr[1], B + 64'd8);
        check("SW/wr1_len",  64'(cap_wr_len[1]), 64'h0003);
        check("SW/wr1_data", cap_wr_data[1], 64'h0000_0000_0000_AABB);
        check("SW/mem0", mem[0], 64'hCCDD_0000_0000_80F0);
        check("SW/mem1", mem[1], 64'h0000_0000_0000_AABB);

        // 4: crossing LW / LWU
        issue(1'b0, 1'b0, 3'b010, B + 64'd6, 64'd0, "LW");
        expect_resp("LW", 3, 1'b0, 64'hFFFF_FFFF_AABB_CCDD, 2, 0);
        check("LW/rd0_addr", cap_rd_addr[0], B);
        check("LW/rd1_addr", cap_rd_addr[1], B + 64'd8);
        issue(1'b0, 1'b0, 3'b110, B + 64'd6, 64'd0, "LWU");
        expect_resp("LWU", 3, 1'b0, 64'h0000_0000_AABB_CCDD, 2, 0);

        // SB to the last byte of a doubleword: no split
        issue(1'b0, 1'b1, 3'b000, B + 64'd7, 64'h0000_0000_0012_345A, "SB7");
        expect_resp("SB7", 2, 1'b0, 64'd0, 0, 1);
        check("SB7/wr_len",  64'(cap_wr_len[0]), 64'h0080);
        check("SB7/wr_data", cap_wr_data[0], 64'h5A00_0000_0000_0000);

        // Misaligned but non-crossing LH on the splitting instance
        issue(1'b0, 1'b0, 3'b001, B + 64'd1, 64'd0, "LHmis");
        expect_resp("LHmis", 2, 1'b0, 64'h0000_0000_0000_0080, 1, 0);

        // 5: error paths
        issue(1'b1, 1'b0, 3'b001, B + 64'd1, 64'd0, "LHmis0");
        expect_resp("LHmis0", 1, 1'b1, 64'd0, 0, 0);
        issue(1'b1, 1'b0, 3'b010, B, 64'd0, "LW0");
        expect_resp("LW0", 2, 1'b0, 64'h0000_0000_0000_80F0, 1, 0);
        issue(1'b0, 1'b1, 3'b100, B, 64'hFFFF, "ST100");
        expect_resp("ST100", 1, 1'b1, 64'd0, 0, 0);
        issue(1'b0, 1'b0, 3'b111, B, 64'd0, "LD111");
        expect_resp("LD111", 1, 1'b1, 64'd0, 0, 0);
        issue(1'b1, 1'b1, 3'b100, B, 64'hFFFF, "ST100_0");
        expect_resp("ST100_0", 1, 1'b1, 64'd0, 0, 0);
        issue(1'b1, 1'b0, 3'b111, B, 64'd0, "LD111_0");
        expect_resp("LD111_0", 1, 1'b1, 64'd0, 0, 0);

        // 6: asynchronous reset during RD0 of a crossing LD
        poke(3'd0, 64'h1122_3344_5566_7788);
        poke(3'd1, 64'h99AA_BBCC_DDEE_FF00);
        req_we = 1'b0; req_funct3 = 3'b011; req_addr = B + 64'd4; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("ARST/rd_en_before",   64'(rd_en), 64'd1);
        check("ARST/rd_addr_before", rd_addr, B);
        #2 rst = 1'b0;
        #1;
        check("ARST/rd_en",      64'(rd_en), 64'd0);
        check("ARST/resp_valid", 64'(resp_valid), 64'd0);
        check("ARST/rd_addr",    rd_addr, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ARST/ready_after", 64'(req_ready), 64'd1);
        issue(1'b0, 1'b0, 3'b011, B + 64'd4, 64'd0, "LDx");
        expect_resp("LDx", 3, 1'b0, 64'hDDEE_FF00_1122_3344, 2, 0);

        // 7: second beat address wraps past the top of the address space
        poke(3'd7, 64'h0123_4567_89AB_CDEF);
        issue(1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, "LDwrap");
        expect_resp("LDwrap", 3, 1'b0, 64'h5566_7788_0123_4567, 2, 0);
        check("LDwrap/rd0_addr", cap_rd_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
        check("LDwrap/rd1_addr", cap_rd_addr[1], 64'd0);

        check("rd_wr_overlap", 64'(both), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
